// File: rtl/tablero_jugadas_if.sv
// Move handshake between the player front-end (master) and the board writer (slave).
interface tablero_jugadas_if;
    logic       mov_valido;
    logic [1:0] mov_fila;
    logic [1:0] mov_col;
    logic       mov_listo;
    logic       mov_ack;
    logic       mov_error;

    modport master (
        output mov_valido, mov_fila, mov_col,
        input  mov_listo, mov_ack, mov_error
    );

    modport slave (
        input  mov_valido, mov_fila, mov_col,
        output mov_listo, mov_ack, mov_error
    );
endinterface

// File: rtl/tablero_jugadas.sv
// Three-in-a-row board writer: accepts moves, alternates turns, times out idle
// players and latches win/draw from the external combinational winner checker.
module tablero_jugadas #(
    parameter int unsigned CICLOS_TURNO = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   nuevo_juego,
    tablero_jugadas_if.slave       mov,
    output logic [2:0][2:0][1:0]   matriz_juego,
    input  logic                   ganador,
    output logic [1:0]             turno,
    output logic [1:0]             estado_juego,
    output logic [1:0]             jugador_ganador,
    output logic                   tiempo_agotado
);

    localparam int unsigned CNT_W = (CICLOS_TURNO > 2) ? $clog2(CICLOS_TURNO) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CICLOS_TURNO - 1);
    localparam int unsigned MOV_W = 4;

    typedef enum logic [1:0] {
        ESPERA     = 2'd0,
        EVALUA     = 2'd1,
        FIN_GANA   = 2'd2,
        FIN_EMPATE = 2'd3
    } estado_t;

    estado_t                r_state;
    estado_t                w_state_nx;
    logic [2:0][2:0][1:0]   r_board;
    logic [2:0][2:0][1:0]   w_board_nx;
    logic [1:0]             r_turno;
    logic [1:0]             w_turno_nx;
    logic [1:0]             r_estado;
    logic [1:0]             w_estado_nx;
    logic [1:0]             r_jg;
    logic [1:0]             w_jg_nx;
    logic                   r_ack;
    logic                   w_ack_nx;
    logic                   r_err;
    logic                   w_err_nx;
    logic                   r_tout;
    logic                   w_tout_nx;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic [MOV_W-1:0]       r_movs;
    logic [MOV_W-1:0]       w_movs_nx;

    logic                   w_en_rango;
    logic [1:0]             w_celda;
    logic                   w_hs;
    logic                   w_legal;
    logic                   w_expira;

    function automatic logic [1:0] otro_jugador(input logic [1:0] t);
        return (t == 2'd1) ? 2'd2 : 2'd1;
    endfunction

    // Handshake decode for the move offered this cycle
    always_comb begin
        w_en_rango = (mov.mov_fila != 2'd3) && (mov.mov_col != 2'd3);
        w_celda    = 2'd0;
        if (w_en_rango)
            w_celda = r_board[mov.mov_fila][mov.mov_col];
        w_hs     = (r_state == ESPERA) && mov.mov_valido;
        w_legal  = w_hs && w_en_rango && (w_celda == 2'd0);
        w_expira = (r_state == ESPERA) && (r_cnt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ESPERA;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (nuevo_juego) begin
            w_state_nx = ESPERA;
        end else begin
            case (r_state)
                ESPERA:  if (w_legal) w_state_nx = EVALUA;
                EVALUA: begin
                    if (ganador)
                        w_state_nx = FIN_GANA;
                    else if (r_movs == MOV_W'(9))
                        w_state_nx = FIN_EMPATE;
                    else
                        w_state_nx = ESPERA;
                end
                default: w_state_nx = r_state;
            endcase
        end
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        w_board_nx  = r_board;
        w_turno_nx  = r_turno;
        w_estado_nx = r_estado;
        w_jg_nx     = r_jg;
        w_ack_nx    = 1'b0;
        w_err_nx    = 1'b0;
        w_tout_nx   = 1'b0;
        w_cnt_nx    = r_cnt;
        w_movs_nx   = r_movs;
        if (nuevo_juego) begin
            w_board_nx  = '0;
            w_turno_nx  = 2'd1;
            w_estado_nx = 2'd0;
            w_jg_nx     = 2'd0;
            w_cnt_nx    = '0;
            w_movs_nx   = '0;
        end else begin
            case (r_state)
                ESPERA: begin
                    // A legal move beats expiry; expiry beats an illegal move so pulses stay exclusive
                    if (w_legal) begin
                        w_board_nx[mov.mov_fila][mov.mov_col] = r_turno;
                        w_movs_nx = r_movs + MOV_W'(1);
                        w_ack_nx  = 1'b1;
                        w_cnt_nx  = '0;
                    end else if (w_expira) begin
                        w_turno_nx = otro_jugador(r_turno);
                        w_tout_nx  = 1'b1;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                        w_err_nx = w_hs;
                    end
                end
                EVALUA: begin
                    w_cnt_nx = '0;
                    if (ganador) begin
                        w_estado_nx = 2'd1;
                        w_jg_nx     = r_turno;
                    end else if (r_movs == MOV_W'(9)) begin
                        w_estado_nx = 2'd2;
                    end else begin
                        w_turno_nx = otro_jugador(r_turno);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_board  <= '0;
            r_turno  <= 2'd1;
            r_estado <= 2'd0;
            r_jg     <= 2'd0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_tout   <= 1'b0;
            r_cnt    <= '0;
            r_movs   <= '0;
        end else begin
            r_board  <= w_board_nx;
            r_turno  <= w_turno_nx;
            r_estado <= w_estado_nx;
            r_jg     <= w_jg_nx;
            r_ack    <= w_ack_nx;
            r_err    <= w_err_nx;
            r_tout   <= w_tout_nx;
            r_cnt    <= w_cnt_nx;
            r_movs   <= w_movs_nx;
        end
    end

    assign mov.mov_listo   = (r_state == ESPERA);
    assign mov.mov_ack     = r_ack;
    assign mov.mov_error   = r_err;
    assign matriz_juego    = r_board;
    assign turno           = r_turno;
    assign estado_juego    = r_estado;
    assign jugador_ganador = r_jg;
    assign tiempo_agotado  = r_tout;

endmodule
